// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock/tick divider. Each channel owns a counter,
// an active config and a shadow config that is swapped in at the channel's wrap.

module clk_div_multi_ch #(
   parameter int CNT_W        = 20,
   parameter int DEFAULT_DIV  = 125000,
   parameter int DEFAULT_MODE = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             sync_i,
   input  logic             wr_i,
   input  logic [CNT_W-1:0] wr_div_i,
   input  logic             wr_mode_i,
   output logic             tick_o,
   output logic             clk_out_o,
   output logic             pending_o
);
   typedef struct packed {
      logic [CNT_W-1:0] div;
      logic             mode;
   } cfg_t;

   localparam cfg_t CFG_RST = '{div: CNT_W'(DEFAULT_DIV), mode: 1'(DEFAULT_MODE)};

   logic [CNT_W-1:0] cnt_q, cnt_d;
   cfg_t             act_q, act_d, shd_q, shd_d, wcfg;
   logic             pend_q, pend_d, tick_q, tick_d, clk_q, clk_d;
   logic             wrap;

   assign wcfg.div  = (wr_div_i == '0) ? CNT_W'(1) : wr_div_i;
   assign wcfg.mode = wr_mode_i;
   assign wrap      = (cnt_q == act_q.div - CNT_W'(1));

   always_comb begin
      cnt_d  = cnt_q;
      act_d  = act_q;
      shd_d  = shd_q;
      pend_d = pend_q;
      tick_d = 1'b0;
      clk_d  = clk_q;
      if (sync_i || !en_i) begin
         cnt_d = '0;
         clk_d = 1'b0;
         if (pend_q) begin
            act_d  = shd_q;
            pend_d = 1'b0;
         end
      end else if (wrap) begin
         // the wrap itself is produced with the outgoing mode
         cnt_d  = '0;
         tick_d = 1'b1;
         if (act_q.mode) clk_d = ~clk_q;
         if (pend_q) begin
            act_d  = shd_q;
            pend_d = 1'b0;
            if (!shd_q.mode) clk_d = 1'b0;
         end
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      // a write on this edge lands after any apply above, so it waits for the next wrap
      if (wr_i) begin
         shd_d = wcfg;
         if (en_i) begin
            pend_d = 1'b1;
         end else begin
            act_d  = wcfg;
            pend_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         act_q  <= CFG_RST;
         shd_q  <= CFG_RST;
         pend_q <= 1'b0;
         tick_q <= 1'b0;
         clk_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         act_q  <= act_d;
         shd_q  <= shd_d;
         pend_q <= pend_d;
         tick_q <= tick_d;
         clk_q  <= clk_d;
      end
   end

   assign tick_o    = tick_q;
   assign clk_out_o = clk_q;
   assign pending_o = pend_q;
endmodule

module clk_div_multi #(
   parameter  int CH           = 4,
   parameter  int CNT_W        = 20,
   parameter  int DEFAULT_DIV  = 125000,
   parameter  int DEFAULT_MODE = 1,
   localparam int CH_W         = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [CH-1:0]    en_i,
   input  logic             sync_i,
   input  logic             cfg_we_i,
   input  logic [CH_W-1:0]  cfg_ch_i,
   input  logic [CNT_W-1:0] cfg_div_i,
   input  logic             cfg_mode_i,
   output logic [CH-1:0]    tick_o,
   output logic [CH-1:0]    clk_out_o,
   output logic [CH-1:0]    pending_o
);
   // out-of-range cfg_ch matches no channel index, so such writes fall away
   for (genvar g = 0; g < CH; g++) begin : g_ch
      localparam logic [CH_W-1:0] IDX = CH_W'(g);

      clk_div_multi_ch #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV),
         .DEFAULT_MODE(DEFAULT_MODE)
      ) u_ch (
         .clk_i    (clk_i),
         .rst_i    (rst_i),
         .en_i     (en_i[g]),
         .sync_i   (sync_i),
         .wr_i     (cfg_we_i && (cfg_ch_i == IDX)),
         .wr_div_i (cfg_div_i),
         .wr_mode_i(cfg_mode_i),
         .tick_o   (tick_o[g]),
         .clk_out_o(clk_out_o[g]),
         .pending_o(pending_o[g])
      );
   end
endmodule

// File: tb/tb_clk_div_multi.sv
// Randomized and directed checks of clk_div_multi against a period-level model.

module tb_clk_div_multi;
   localparam int CH = 4, CNT_W = 8, DDIV = 4, DMODE = 1, CH_W = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1, sync = 1'b0, cfg_we = 1'b0, cfg_mode = 1'b0;
   logic [CH-1:0]    en = '0;
   logic [CH_W-1:0]  cfg_ch = '0;
   logic [CNT_W-1:0] cfg_div = '0;
   logic [CH-1:0]    tick, clk_out, pending;

   int checks = 0, errors = 0;

   // model: elapsed edges in the current period, active/shadow settings per channel
   int m_el[CH], m_div[CH], m_mode[CH], s_div[CH], s_mode[CH];
   bit m_pend[CH], m_tick[CH], m_clk[CH];

   clk_div_multi #(.CH(CH), .CNT_W(CNT_W), .DEFAULT_DIV(DDIV), .DEFAULT_MODE(DMODE)) dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .sync_i(sync), .cfg_we_i(cfg_we),
      .cfg_ch_i(cfg_ch), .cfg_div_i(cfg_div), .cfg_mode_i(cfg_mode),
      .tick_o(tick), .clk_out_o(clk_out), .pending_o(pending));

   always #5 clk = ~clk;

   function automatic void model_edge();
      int nd;
      nd = (cfg_div == 0) ? 1 : int'(cfg_div);
      for (int c = 0; c < CH; c++) begin
         if (rst) begin
            m_el[c] = 0; m_div[c] = DDIV; m_mode[c] = DMODE; s_div[c] = DDIV; s_mode[c] = DMODE;
            m_pend[c] = 0; m_tick[c] = 0; m_clk[c] = 0;
         end else begin
            if (sync || !en[c]) begin
               m_el[c] = 0; m_tick[c] = 0; m_clk[c] = 0;
               if (m_pend[c]) begin m_div[c] = s_div[c]; m_mode[c] = s_mode[c]; m_pend[c] = 0; end
            end else begin
               m_el[c]++;
               m_tick[c] = (m_el[c] == m_div[c]);
               if (m_tick[c]) begin
                  m_el[c] = 0;
                  if (m_mode[c] == 1) m_clk[c] = !m_clk[c];
                  if (m_pend[c]) begin
                     m_div[c] = s_div[c]; m_mode[c] = s_mode[c]; m_pend[c] = 0;
                     if (m_mode[c] == 0) m_clk[c] = 0;
                  end
               end
            end
            if (cfg_we && int'(cfg_ch) == c) begin
               s_div[c] = nd; s_mode[c] = int'(cfg_mode);
               if (en[c]) m_pend[c] = 1;
               else begin m_div[c] = nd; m_mode[c] = int'(cfg_mode); m_pend[c] = 0; end
            end
         end
      end
   endfunction

   function automatic logic [3*CH-1:0] exp_outs();
      logic [CH-1:0] t, k, p;
      for (int c = 0; c < CH; c++) begin t[c] = m_tick[c]; k[c] = m_clk[c]; p[c] = m_pend[c]; end
      return {t, k, p};
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = '1;
      step(); step();
      checks++;
      if ({tick, clk_out, pending} !== '0) begin
         errors++; $display("FAIL reset_outs got %h want 0", {tick, clk_out, pending});
      end
      rst = 1'b0;
   endtask

   task automatic test_defaults();
      int nt;
      nt = 0;
      en = '1;
      for (int i = 1; i <= 16; i++) begin
         step();
         checks++;
         if ({tick, clk_out, pending} !== exp_outs()) begin
            errors++; $display("FAIL defaults_model edge %0d got %h want %h", i, {tick, clk_out, pending}, exp_outs());
         end
         if (tick[0]) nt++;
         if (i == 3 || i == 4) begin
            checks++;
            if (tick !== ((i == 4) ? 4'hF : 4'h0)) begin
               errors++; $display("FAIL defaults_first_tick edge %0d got %h", i, tick);
            end
         end
         if (i == 4 || i == 8) begin
            checks++;
            if (clk_out !== ((i == 4) ? 4'hF : 4'h0)) begin
               errors++; $display("FAIL defaults_clk_out edge %0d got %h", i, clk_out);
            end
         end
      end
      checks++;
      if (nt != 4) begin errors++; $display("FAIL defaults_tick_count got %0d want 4", nt); end
   endtask

   task automatic test_write_running();
      bit done;
      done = 0;
      cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd3; cfg_mode = 1'b0;
      step();
      cfg_we = 1'b0;
      checks++;
      if (pending !== 4'b0100) begin errors++; $display("FAIL wr_run_pending got %b want 0100", pending); end
      for (int i = 0; i < 20; i++) begin
         step();
         checks++;
         if ({tick, clk_out, pending} !== exp_outs()) begin
            errors++; $display("FAIL wr_run_model cyc %0d got %h want %h", i, {tick, clk_out, pending}, exp_outs());
         end
         if (!pending[2]) done = 1;
      end
      checks++;
      if (!done) begin errors++; $display("FAIL wr_run_apply_timeout pending stuck 1 want 0"); end
   endtask

   task automatic test_disabled_write();
      logic prev;
      en = 4'b1101;
      step();
      cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd0; cfg_mode = 1'b1;
      step();
      cfg_we = 1'b0;
      checks++;
      if (pending[1] !== 1'b0) begin errors++; $display("FAIL dis_wr_pending got %b want 0", pending[1]); end
      en = '1;
      prev = clk_out[1];
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (tick[1] !== 1'b1 || clk_out[1] === prev) begin
            errors++; $display("FAIL dis_wr_div1 cyc %0d tick %b clk %b prev %b", i, tick[1], clk_out[1], prev);
         end
         checks++;
         if ({tick, clk_out, pending} !== exp_outs()) begin
            errors++; $display("FAIL dis_wr_model cyc %0d got %h want %h", i, {tick, clk_out, pending}, exp_outs());
         end
         prev = clk_out[1];
      end
   endtask

   task automatic test_coincident();
      int n;
      n = 0;
      while (m_el[0] != m_div[0] - 1 && n < 20) begin step(); n++; end
      checks++;
      if (n >= 20) begin errors++; $display("FAIL coinc_wait_timeout el %0d want %0d", m_el[0], m_div[0] - 1); end
      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd5; cfg_mode = 1'b1;
      step();
      checks++;
      if (tick[0] !== 1'b1 || pending[0] !== 1'b1) begin
         errors++; $display("FAIL coinc_wrap tick %b pend %b want 1 1", tick[0], pending[0]);
      end
      // old D=4 still runs; a second write (D=6) before the apply wins
      for (int k = 1; k <= 16; k++) begin
         cfg_we = (k == 1); cfg_div = 8'd6;
         step();
         cfg_we = 1'b0;
         checks++;
         if (tick[0] !== (k == 4 || k == 10 || k == 16)) begin
            errors++; $display("FAIL coinc_tick k %0d got %b", k, tick[0]);
         end
         checks++;
         if ({tick, clk_out, pending} !== exp_outs()) begin
            errors++; $display("FAIL coinc_model k %0d got %h want %h", k, {tick, clk_out, pending}, exp_outs());
         end
      end
   endtask

   task automatic test_sync();
      int n;
      n = 0;
      cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd2; cfg_mode = 1'b1;
      step();
      cfg_we = 1'b0;
      while (m_el[3] != m_div[3] - 1 && n < 20) begin step(); n++; end
      checks++;
      if (n >= 20 || pending[3] !== 1'b1) begin
         errors++; $display("FAIL sync_wait n %0d pend %b want 1", n, pending[3]);
      end
      sync = 1'b1;
      step();
      sync = 1'b0;
      checks++;
      if (tick !== 4'h0 || clk_out !== 4'h0 || pending !== 4'h0) begin
         errors++; $display("FAIL sync_clear tick %h clk %h pend %h want 0 0 0", tick, clk_out, pending);
      end
      for (int i = 0; i < 12; i++) begin
         step();
         checks++;
         if ({tick, clk_out, pending} !== exp_outs()) begin
            errors++; $display("FAIL sync_model cyc %0d got %h want %h", i, {tick, clk_out, pending}, exp_outs());
         end
      end
   endtask

   task automatic test_rst_mid();
      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd7; cfg_mode = 1'b0;
      step();
      checks++;
      if (pending[0] !== 1'b1) begin errors++; $display("FAIL rst_mid_pending got %b want 1", pending[0]); end
      cfg_ch = 2'd1; rst = 1'b1; sync = 1'b1;
      step();
      rst = 1'b0; sync = 1'b0; cfg_we = 1'b0;
      checks++;
      if ({tick, clk_out, pending} !== '0) begin
         errors++; $display("FAIL rst_mid_outs got %h want 0", {tick, clk_out, pending});
      end
      for (int i = 1; i <= 12; i++) begin
         step();
         checks++;
         if (tick !== ((i % DDIV == 0) ? 4'hF : 4'h0)) begin
            errors++; $display("FAIL rst_mid_default_div edge %0d got %h", i, tick);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 249) == 0);
         sync = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 19) == 0) en = 4'($urandom);
         cfg_we = ($urandom_range(0, 4) == 0);
         cfg_ch = 2'($urandom);
         cfg_div = 8'($urandom_range(0, 9));
         cfg_mode = 1'($urandom);
         step();
         checks++;
         if ({tick, clk_out, pending} !== exp_outs()) begin
            errors++; $display("FAIL random_model cyc %0d got %h want %h", i, {tick, clk_out, pending}, exp_outs());
         end
      end
      rst = 1'b0; sync = 1'b0; cfg_we = 1'b0;
   endtask

   initial begin
      test_reset();
      test_defaults();
      test_write_running();
      test_disabled_write();
      test_coincident();
      test_sync();
      test_rst_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
